// File: rtl/pb_soc_bus_pkg.sv
// Shared encodings and width defaults for the two-requester register-bus arbiter.
package pb_soc_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_e;

endpackage

// File: rtl/pb_soc_rr_arb2.sv
// Combinational two-way round-robin pick; a tie goes to the requester that did not win last.
module pb_soc_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/pb_soc_bus_arbiter.sv
// Shares one register-file port between two requesters; each transaction is
// IDLE -> ACCESS (one strobe cycle) -> ACK (one completion pulse).
//
//   state     | meaning
//   ST_IDLE   | bus free, arbitrate and latch the winner's command
//   ST_ACCESS | rd_o or wr_o high for exactly this cycle
//   ST_ACK    | winner's ack high, read data already captured
module pb_soc_bus_arbiter
  import pb_soc_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              rd_o,
  output logic              wr_o,
  input  logic [DATA_W-1:0] data_i
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [1:0]          grant;

  pb_soc_rr_arb2 u_arb (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // last_grant_q doubles as the in-flight winner: it is loaded on IDLE->ACCESS
  // and not touched again until the next IDLE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    ack_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          last_grant_d = grant[1];
          addr_d       = grant[1] ? m1_addr  : m0_addr;
          data_d       = grant[1] ? m1_wdata : m0_wdata;
          wr_d         = grant[1] ? m1_we    : m0_we;
          rd_d         = grant[1] ? ~m1_we   : ~m0_we;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ack_d = last_grant_q ? 2'b10 : 2'b01;
        if (rd_q) begin
          if (last_grant_q) rdata1_d = data_i;
          else              rdata0_d = data_i;
        end
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign addr_o   = addr_q;
  assign data_o   = data_q;
  assign rd_o     = rd_q;
  assign wr_o     = wr_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_pb_soc_bus_arbiter.sv
// Directed bench for pb_soc_bus_arbiter with a small register-file model on the bus side.
module tb_pb_soc_bus_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] addr_o, data_o, data_i;
  logic       rd_o, wr_o;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  pb_soc_bus_arbiter dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .rd_o     (rd_o),
    .wr_o     (wr_o),
    .data_i   (data_i)
  );

  always @(posedge clk_i) begin
    if (pre_we)    mem[pre_addr] <= pre_data;
    else if (wr_o) mem[addr_o]   <= data_o;
  end
  assign data_i = mem[addr_o];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    preload(8'h1C, 8'hA5);
    preload(8'h10, 8'h11);
    preload(8'h20, 8'h22);
    preload(8'h40, 8'h00);
    tick();
    rst_i = 1'b0;

    check("rst_rd",     rd_o,     1'b0);
    check("rst_wr",     wr_o,     1'b0);
    check("rst_addr",   addr_o,   8'h00);
    check("rst_data",   data_o,   8'h00);
    check("rst_ack0",   m0_ack,   1'b0);
    check("rst_ack1",   m1_ack,   1'b0);
    check("rst_rdata0", m0_rdata, 8'h00);
    check("rst_rdata1", m1_rdata, 8'h00);

    // m0 write alone
    m0_req = 1; m0_we = 1; m0_addr = 8'h03; m0_wdata = 8'h5A;
    tick();
    check("w_wr",    wr_o,   1'b1);
    check("w_rd",    rd_o,   1'b0);
    check("w_addr",  addr_o, 8'h03);
    check("w_data",  data_o, 8'h5A);
    check("w_noack", m0_ack, 1'b0);
    m0_addr = 8'hFF; m0_wdata = 8'h00;
    tick();
    check("w_ack0",  m0_ack, 1'b1);
    check("w_ack1",  m1_ack, 1'b0);
    check("w_wroff", wr_o,   1'b0);
    m0_req = 0;
    tick();
    check("w_ackoff",  m0_ack, 1'b0);
    check("w_addrhld", addr_o, 8'h03);
    check("w_datahld", data_o, 8'h5A);

    // m1 read alone
    m1_req = 1; m1_we = 0; m1_addr = 8'h1C;
    tick();
    check("r_rd",   rd_o,   1'b1);
    check("r_wr",   wr_o,   1'b0);
    check("r_addr", addr_o, 8'h1C);
    tick();
    check("r_ack1",   m1_ack,   1'b1);
    check("r_ack0",   m0_ack,   1'b0);
    check("r_rdata1", m1_rdata, 8'hA5);
    check("r_rdata0", m0_rdata, 8'h00);
    check("r_rdoff",  rd_o,     1'b0);
    m1_req = 0;
    tick();

    // tie after reset: m0, m1, m0, m1
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 8'h10;
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_addr", addr_o, (k % 2 == 0) ? 8'h10 : 8'h20);
      check("rr_rd",   rd_o,   1'b1);
      tick();
      check("rr_ack0", m0_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_ack1", m1_ack, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k % 2 == 0) check("rr_rdata0", m0_rdata, 8'h11);
      else            check("rr_rdata1", m1_rdata, 8'h22);
      if (k == 3) begin m0_req = 0; m1_req = 0; end
      tick();
      check("rr_idle", m0_ack | m1_ack, 1'b0);
    end

    // m0 streaming writes, m1 read arrives mid-stream
    m0_req = 1; m0_we = 1; m0_addr = 8'h40; m0_wdata = 8'h01;
    tick();
    check("s_wr0",  wr_o,   1'b1);
    check("s_addr", addr_o, 8'h40);
    m1_req = 1; m1_we = 0; m1_addr = 8'h40;
    tick();
    check("s_ack0", m0_ack, 1'b1);
    tick();
    tick();
    check("s_m1rd", rd_o, 1'b1);
    check("s_m1wr", wr_o, 1'b0);
    tick();
    check("s_ack1",   m1_ack,   1'b1);
    check("s_m1data", m1_rdata, 8'h01);
    check("s_m0keep", m0_rdata, 8'h11);
    m1_req = 0;
    tick();
    tick();
    check("s_m0again", wr_o, 1'b1);
    tick();
    check("s_ack0b", m0_ack, 1'b1);
    m0_req = 0;
    tick();

    // reset during a write's ACCESS cycle
    m0_req = 1; m0_we = 1; m0_addr = 8'h50; m0_wdata = 8'h99;
    tick();
    check("a_wr", wr_o, 1'b1);
    rst_i = 1; m0_req = 0;
    tick();
    check("a_wroff",  wr_o,     1'b0);
    check("a_rdoff",  rd_o,     1'b0);
    check("a_noack",  m0_ack,   1'b0);
    check("a_rdata0", m0_rdata, 8'h00);
    rst_i = 0;
    tick();
    check("a_noack2", m0_ack | m1_ack, 1'b0);
    m0_req = 1; m0_we = 0; m0_addr = 8'h40;
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    tick();
    check("a_tieaddr", addr_o, 8'h40);
    tick();
    check("a_ack0",   m0_ack,   1'b1);
    check("a_ack1",   m1_ack,   1'b0);
    check("a_rdata0b", m0_rdata, 8'h01);
    check("a_rdata1",  m1_rdata, 8'h00);
    m0_req = 0; m1_req = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pb_soc_bus_arbiter.md
PB_SOC_BUS_ARBITER -- requirements
Module: pb_soc_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: register-bus address width.
REQ-002 Parameter DATA_W, default 8: register-bus data width.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-005 m0_req  input  1  requester 0 transaction request, held high until m0_ack.
REQ-006 m0_we  input  1  requester 0 direction: 1 write, 0 read.
REQ-007 m0_addr  input  ADDR_W  requester 0 register address.
REQ-008 m0_wdata  input  DATA_W  requester 0 write data.
REQ-009 m0_ack  output  1  requester 0 completion pulse, one cycle.
REQ-010 m0_rdata  output  DATA_W  requester 0 read data, valid while m0_ack=1.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: identical to REQ-005..010 for requester 1.
REQ-012 addr_o  output  ADDR_W  register-file address.
REQ-013 data_o  output  DATA_W  register-file write data.
REQ-014 rd_o  output  1  register-file read strobe.
REQ-015 wr_o  output  1  register-file write strobe.
REQ-016 data_i  input  DATA_W  register-file read data, combinational from addr_o while rd_o=1.

Function
REQ-017 FSM states: IDLE, ACCESS, ACK; exactly one register-bus transaction per ACCESS visit.
REQ-018 IDLE: no request -> stay IDLE; any req high -> pick winner, load addr_o/data_o/rd_o/wr_o from winner, go ACCESS.
REQ-019 Arbitration: round-robin on last_grant; both req high -> grant requester != last_grant; single req -> grant it regardless of last_grant.
REQ-020 last_grant updates to the winner on the IDLE->ACCESS edge.
REQ-021 ACCESS lasts exactly one cycle; rd_o = ~we, wr_o = we of winner; then go ACK.
REQ-022 On the ACCESS->ACK edge, read transactions capture data_i into the winner's rdata; writes leave rdata unchanged.
REQ-023 ACK lasts one cycle: winner's ack=1, other ack=0, rd_o=wr_o=0; then go IDLE.
REQ-024 Latency: req sampled high in IDLE cycle N -> strobe in cycle N+1 -> ack in cycle N+2; minimum 3 cycles per transaction.
REQ-025 Requester drops req in the cycle after ack; req still high in that IDLE cycle counts as a new transaction.
REQ-026 req changes while not granted, and addr/we/wdata changes after the IDLE->ACCESS edge, do not affect the transaction in flight.
REQ-027 addr_o and data_o hold their last values outside ACCESS; rd_o and wr_o are high only in ACCESS, never both.
REQ-028 m0_rdata and m1_rdata hold their values between reads.

Reset
REQ-029 rst_i high: state=IDLE, last_grant=1 (requester 0 wins first tie), rd_o=wr_o=0, addr_o=data_o=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
REQ-030 Reset during ACCESS or ACK aborts the transaction: no ack is issued and strobes are low from the next cycle.

Structure
REQ-031 Package pb_soc_bus_pkg holds the state encoding (IDLE=2'b00, ACCESS=2'b01, ACK=2'b10) and the ADDR_W/DATA_W defaults.
REQ-032 The combinational 2-way round-robin pick is a sub-module named pb_soc_rr_arb2 (inputs req[1:0] and last_grant; outputs a one-hot grant).

Verification
REQ-033 m0 write addr 0x03 data 0x5A alone -> wr_o=1 one cycle with addr_o=0x03, data_o=0x5A; m0_ack at N+2; m1_ack stays 0.
REQ-034 m1 read addr 0x1C while data_i=0xA5 -> rd_o=1 one cycle; m1_rdata=0xA5 with m1_ack=1 at N+2.
REQ-035 m0 and m1 requesting together after reset, both held high -> grant order m0, m1, m0, m1, with an ack every 3 cycles.
REQ-036 m0 continuous back-to-back requests, m1 asserts mid-stream -> m1 granted at the next IDLE; m0 waits no more than one transaction.
REQ-037 rst_i asserted during ACCESS of a write -> no ack; state IDLE; next tie goes to m0.
REQ-038 Write then read to the same address from different requesters -> read returns the written value; rdata of the writer is unchanged.
